// File: rtl/i2c_arbiter_seq.sv
// Shares one I2C controller between a CPU requester (A) and a fixed HW requester (B):
// round-robin grant, launch/finish handshake with the controller, and timeout abort.
module i2c_arbiter_seq #(
    parameter int TIMEOUT     = 100000,
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_a_req,
    input  logic [6:0]  i_a_dev_addr,
    input  logic [7:0]  i_a_reg_addr,
    input  logic [7:0]  i_a_w_data,
    input  logic        i_a_rw,
    input  logic [1:0]  i_a_mode,
    input  logic        i_b_drdy,
    input  logic [31:0] i_status,
    output logic [31:0] o_ctrl,
    output logic [6:0]  o_dev_addr,
    output logic [7:0]  o_reg_addr,
    output logic [7:0]  o_w_data,
    output logic        o_a_done,
    output logic        o_b_done,
    output logic        o_err,
    output logic [1:0]  o_grant,
    output logic        o_busy
);
    // state   | meaning
    // IDLE    | waiting for controller ready and a pending request
    // GRANT   | owner chosen, transaction fields latched
    // LAUNCH  | enable raised, waiting for controller to drop ready
    // BUSY    | transfer running, waiting for a rising edge on finish
    // RELEASE | finish acknowledged, waiting for ready high and finish low
    // ABORT   | timed out, waiting for ready before returning to IDLE
    typedef enum logic [2:0] {IDLE, GRANT, LAUNCH, BUSY, RELEASE, ABORT} state_t;

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state;
    logic [1:0]    sync_q [SYNC_STAGES];
    logic          rdy_s;
    logic          fin_s;
    logic          fin_prev;
    logic [TW-1:0] tcnt;
    logic          b_first;
    logic          owner_b;
    logic          en;
    logic          rw;
    logic          ack;
    logic [1:0]    mode;
    logic          pick_b;
    logic          timed_out;
    logic          unused_status;

    assign rdy_s         = sync_q[SYNC_STAGES-1][0];
    assign fin_s         = sync_q[SYNC_STAGES-1][1];
    assign pick_b        = i_b_drdy && (!i_a_req || b_first);
    assign timed_out     = (tcnt == TW'(TIMEOUT - 1));
    assign o_ctrl        = {27'd0, ack, mode, rw, en};
    assign o_busy        = (state != IDLE);
    assign unused_status = ^i_status[31:2];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 2'b00;
        end else begin
            sync_q[0] <= i_status[1:0];
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            tcnt       <= '0;
            fin_prev   <= 1'b0;
            b_first    <= 1'b1;
            owner_b    <= 1'b0;
            en         <= 1'b0;
            rw         <= 1'b0;
            mode       <= 2'b00;
            ack        <= 1'b0;
            o_dev_addr <= 7'd0;
            o_reg_addr <= 8'd0;
            o_w_data   <= 8'd0;
            o_a_done   <= 1'b0;
            o_b_done   <= 1'b0;
            o_err      <= 1'b0;
            o_grant    <= 2'd0;
        end else begin
            fin_prev <= fin_s;
            ack      <= 1'b0;
            o_a_done <= 1'b0;
            o_b_done <= 1'b0;
            if (state inside {LAUNCH, BUSY, RELEASE}) tcnt <= tcnt + 1'b1;

            case (state)
                IDLE: begin
                    if (rdy_s && (i_a_req || i_b_drdy)) begin
                        state   <= GRANT;
                        o_err   <= 1'b0;
                        owner_b <= pick_b;
                        b_first <= !pick_b;
                        o_grant <= pick_b ? 2'd2 : 2'd1;
                        if (pick_b) begin
                            o_dev_addr <= 7'h1D;
                            o_reg_addr <= 8'h06;
                            o_w_data   <= 8'h00;
                            rw         <= 1'b1;
                            mode       <= 2'd2;
                        end else begin
                            o_dev_addr <= i_a_dev_addr;
                            o_reg_addr <= i_a_reg_addr;
                            o_w_data   <= i_a_w_data;
                            rw         <= i_a_rw;
                            // only single-byte and 11-byte modes exist for the CPU side
                            mode       <= i_a_mode[1] ? 2'b00 : i_a_mode;
                        end
                    end
                end
                GRANT: begin
                    tcnt  <= '0;
                    en    <= 1'b1;
                    state <= LAUNCH;
                end
                LAUNCH: begin
                    if (timed_out) begin
                        state <= ABORT;
                        en    <= 1'b0;
                        o_err <= 1'b1;
                    end else if (!rdy_s) begin
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    // ready may return high between the address-write and read phases;
                    // only a finish edge ends the transfer
                    if (timed_out) begin
                        state <= ABORT;
                        en    <= 1'b0;
                        o_err <= 1'b1;
                    end else if (fin_s && !fin_prev) begin
                        state    <= RELEASE;
                        en       <= 1'b0;
                        ack      <= 1'b1;
                        o_a_done <= !owner_b;
                        o_b_done <= owner_b;
                    end
                end
                RELEASE: begin
                    if (timed_out) begin
                        state <= ABORT;
                        en    <= 1'b0;
                        o_err <= 1'b1;
                    end else if (rdy_s && !fin_s) begin
                        state   <= IDLE;
                        o_grant <= 2'd0;
                    end
                end
                ABORT: begin
                    if (rdy_s) begin
                        state   <= IDLE;
                        o_grant <= 2'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/i2c_arbiter_seq.md
I2C_ARBITER_SEQ -- requirements
Module: i2c_arbiter_seq

Interface
REQ-001 SHALL have parameter TIMEOUT, default 100000, meaning i_clk cycles allowed per transaction before abort.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth on i_status[1:0].
REQ-003 SHALL use one clock and an asynchronous, active-high reset, with ports as follows.
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports (name  direction  width  meaning):
- i_a_req  in  1  CPU requester transaction request, level.
- i_a_dev_addr  in  7  CPU device address.
- i_a_reg_addr  in  8  CPU register address.
- i_a_w_data  in  8  CPU write data.
- i_a_rw  in  1  CPU rw (1 = read).
- i_a_mode  in  2  CPU op mode: 0 = 1 byte, 1 = 11 bytes.
- i_b_drdy  in  1  HW requester data-ready, level.
- i_status  in  32  controller status: bit0 ready, bit1 finish.
- o_ctrl  out  32  controller control: bit0 enable, bit1 rw, bits3:2 mode, bit4 finish_ack, others 0.
- o_dev_addr  out  7  address to controller.
- o_reg_addr  out  8  register to controller.
- o_w_data  out  8  write data to controller.
- o_a_done  out  1  CPU transaction complete, 1-cycle pulse.
- o_b_done  out  1  HW transaction complete, 1-cycle pulse.
- o_err  out  1  timeout flag, sticky until next grant.
- o_grant  out  2  current owner: 0 none, 1 A, 2 B.
- o_busy  out  1  high when state is not IDLE.

Function
REQ-005 SHALL pass i_status[1:0] through SYNC_STAGES flops before use (rdy_s, fin_s); all other inputs are i_clk-synchronous.
REQ-006 SHALL implement states IDLE, GRANT, LAUNCH, BUSY, RELEASE, ABORT.
REQ-007 In IDLE with rdy_s = 1, SHALL grant to a pending requester on the next cycle (-> GRANT); with rdy_s = 0 SHALL stay in IDLE.
REQ-008 On simultaneous i_a_req and i_b_drdy, SHALL grant round-robin: the requester not served last wins; after reset, B has priority.
REQ-009 In GRANT, SHALL latch the owner's fields into o_dev_addr, o_reg_addr, o_w_data and o_ctrl[3:1]:
- B: dev 7'h1D, reg 8'h06, w_data 0, rw 1, mode 2.
- A: from i_a_*; i_a_mode = 2 or 3 is forced to 0.
REQ-010 GRANT SHALL go to LAUNCH in 1 cycle; o_ctrl[0] = 1 from LAUNCH through BUSY.
REQ-011 LAUNCH SHALL go to BUSY when rdy_s falls.
REQ-012 BUSY SHALL go to RELEASE on the rising edge of fin_s.
REQ-013 Read-mode transactions include the controller's internal address-write phase; fin_s does not rise after that phase, so the sequencer SHALL NOT treat rdy_s returning high mid-transaction as completion.
REQ-014 On entry to RELEASE, SHALL drop o_ctrl[0], pulse o_ctrl[4] for 1 cycle, and pulse the owner's o_x_done for 1 cycle; RELEASE SHALL go to IDLE when rdy_s = 1 and fin_s = 0.
REQ-015 A timeout counter SHALL clear on GRANT and increment every cycle in LAUNCH, BUSY and RELEASE; on reaching TIMEOUT it SHALL go to ABORT.
REQ-016 ABORT SHALL set o_err, drop o_ctrl[0], emit no done pulse, and return to IDLE when rdy_s = 1.
REQ-017 o_err SHALL clear on the next GRANT.
REQ-018 A requester deasserting its request after GRANT SHALL NOT cancel the transaction.
REQ-019 i_b_drdy held high SHALL be re-granted only after a full return to IDLE, at most once per IDLE visit.
REQ-020 Latched fields SHALL be stable from GRANT until the return to IDLE; input changes during that window are ignored.
REQ-021 Requests arriving in a non-IDLE state SHALL be held pending (level-sensitive), not dropped.

Reset
REQ-022 While i_rst = 1, SHALL force: state IDLE, o_ctrl 0, o_dev_addr 0, o_reg_addr 0, o_w_data 0, o_a_done 0, o_b_done 0, o_err 0, o_grant 0, o_busy 0, round-robin pointer = B-first, timeout counter 0, synchronizers 0.
REQ-023 Reset asserted mid-transaction SHALL take effect asynchronously, dropping o_ctrl[0] immediately; after release the block waits in IDLE for rdy_s = 1.

Verification
REQ-024 A write: i_a_req, dev 7'h1D, reg 8'h2C, data 8'h83, rw 0, mode 0; controller model clears ready, then finish pulses -> o_ctrl = 32'h1 while busy, one o_a_done pulse, o_grant 1 -> 0.
REQ-025 Simultaneous i_a_req and i_b_drdy after reset -> B granted first (o_ctrl[3:1] = 3'b101, dev 7'h1D, reg 8'h06), then A; exactly one done pulse each.
REQ-026 Controller model never asserts finish, TIMEOUT = 50 -> ABORT reached 50 cycles after LAUNCH, o_err = 1, no done pulse; next grant clears o_err.
REQ-027 A read, mode 1; ready toggles high between address-write and read phases -> no done pulse until the finish edge; o_a_done pulses exactly once.
REQ-028 i_rst pulsed during BUSY -> o_ctrl = 0 in the same cycle, all outputs at reset values; a new i_a_req completes normally.
REQ-029 i_a_mode = 3 requested -> o_ctrl[3:2] = 2'b00.
